// File: rtl/datapath_controller_pkg.sv
// Shared encodings for the Simple RISC controller: state codes, opcode/op fields,
// register-select and write-back mux codes, and the DECODE branch function.
package datapath_controller_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT   = 4'd0,
        S_DECODE = 4'd1,
        S_WR_IMM = 4'd2,
        S_GET_A  = 4'd3,
        S_GET_B  = 4'd4,
        S_ALU    = 4'd5,
        S_CMP_ST = 4'd6,
        S_WR_RD  = 4'd7
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
    } instr_t;

    // Branch taken out of DECODE; anything unrecognised returns to WAIT with no strobes.
    function automatic state_t decode_next(instr_t i);
        state_t nxt;
        nxt = S_WAIT;
        if (i.opcode == OPC_MOV) begin
            if (i.op == OP_MOV_IMM)      nxt = S_WR_IMM;
            else if (i.op == OP_MOV_REG) nxt = S_GET_B;
        end else if (i.opcode == OPC_ALU) begin
            nxt = (i.op == OP_MVN) ? S_GET_B : S_GET_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/datapath_controller.sv
// Moore FSM sequencing the Simple RISC datapath, one instruction per start pulse.
// Latency from s sampled: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, undefined 2 edges; s only seen in WAIT.
module datapath_controller
    import datapath_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       w
);

    state_t state;
    state_t state_nxt;
    instr_t ir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_WAIT;
        else       state <= state_nxt;
    end

    // Instruction is captured once at start so a decoder reload mid-instruction cannot steer us.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      ir <= '0;
        else if (state == S_WAIT && s)  ir <= '{opcode: opcode, op: op};
    end

    always_comb begin
        state_nxt = S_WAIT;
        case (state)
            S_WAIT:   state_nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: state_nxt = decode_next(ir);
            S_WR_IMM: state_nxt = S_WAIT;
            S_GET_A:  state_nxt = S_GET_B;
            S_GET_B:  state_nxt = (ir.opcode == OPC_ALU && ir.op == OP_CMP) ? S_CMP_ST : S_ALU;
            S_ALU:    state_nxt = S_WR_RD;
            S_CMP_ST: state_nxt = S_WAIT;
            S_WR_RD:  state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        write = 1'b0;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        w     = 1'b0;
        case (state)
            S_WAIT:   w = 1'b1;
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_GET_A:  begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B:  begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            // MOV-reg passes Rm through the adder by zeroing the A operand.
            S_ALU:    begin
                loadc = 1'b1;
                asel  = (ir.opcode == OPC_MOV);
            end
            S_CMP_ST: loads = 1'b1;
            S_WR_RD:  begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed scoreboard bench for datapath_controller: stimulus queues per-cycle
// expected control vectors, an independent monitor pops and compares each cycle.
module tb_datapath_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, asel, bsel, loadc, loads, w;

    datapath_controller dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .w(w)
    );

    always #5 clk = ~clk;

    // {w, nsel[2:0], vsel[1:0], write, loada, loadb, asel, bsel, loadc, loads}
    localparam logic [12:0] E_WAIT  = 13'b1_000_00_0000000;
    localparam logic [12:0] E_DEC   = 13'b0_000_00_0000000;
    localparam logic [12:0] E_WRIMM = 13'b0_001_10_1000000;
    localparam logic [12:0] E_GETA  = 13'b0_001_00_0100000;
    localparam logic [12:0] E_GETB  = 13'b0_100_00_0010000;
    localparam logic [12:0] E_ALU0  = 13'b0_000_00_0000010;
    localparam logic [12:0] E_ALU1  = 13'b0_000_00_0001010;
    localparam logic [12:0] E_CMP   = 13'b0_000_00_0000001;
    localparam logic [12:0] E_WRRD  = 13'b0_010_00_1000000;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [12:0] ctl();
        return {w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads};
    endfunction

    task automatic push(input string tag, input logic [12:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Monitor: one comparison per cycle while expectations are pending.
    initial begin
        logic [12:0] e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, ctl(), e);
            end
        end
    end

    task automatic start(input logic [2:0] opc, input logic [1:0] o);
        @(negedge clk);
        opcode = opc;
        op     = o;
        s      = 1'b1;
    endtask

    task automatic release_s();
        @(negedge clk);
        s = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        #1;
        check("reset_async", ctl(), E_WAIT);
        push("reset_hold0", E_WAIT);
        push("reset_hold1", E_WAIT);
        push("reset_hold2", E_WAIT);
        drain();
        @(negedge clk);
        s     = 1'b0;
        reset = 1'b0;

        // MOV R0,#7
        start(3'b110, 2'b10);
        push("movi_dec", E_DEC); push("movi_wr", E_WRIMM); push("movi_w", E_WAIT);
        release_s();
        drain();

        // ADD
        start(3'b101, 2'b00);
        push("add_dec", E_DEC); push("add_geta", E_GETA); push("add_getb", E_GETB);
        push("add_alu", E_ALU0); push("add_wr", E_WRRD); push("add_w", E_WAIT);
        release_s();
        drain();

        // CMP: status load, never a write
        start(3'b101, 2'b01);
        push("cmp_dec", E_DEC); push("cmp_geta", E_GETA); push("cmp_getb", E_GETB);
        push("cmp_st", E_CMP); push("cmp_w", E_WAIT);
        release_s();
        drain();

        // MVN skips GET_A
        start(3'b101, 2'b11);
        push("mvn_dec", E_DEC); push("mvn_getb", E_GETB); push("mvn_alu", E_ALU0);
        push("mvn_wr", E_WRRD); push("mvn_w", E_WAIT);
        release_s();
        drain();

        // MOV Rd,Rm: A operand forced to zero
        start(3'b110, 2'b00);
        push("movr_dec", E_DEC); push("movr_getb", E_GETB); push("movr_alu", E_ALU1);
        push("movr_wr", E_WRRD); push("movr_w", E_WAIT);
        release_s();
        drain();

        // AND behaves as ADD in control
        start(3'b101, 2'b10);
        push("and_dec", E_DEC); push("and_geta", E_GETA); push("and_getb", E_GETB);
        push("and_alu", E_ALU0); push("and_wr", E_WRRD); push("and_w", E_WAIT);
        release_s();
        drain();

        // Undefined opcode and undefined MOV variant
        start(3'b000, 2'b00);
        push("undef_dec", E_DEC); push("undef_w", E_WAIT); push("undef_idle", E_WAIT);
        release_s();
        drain();
        start(3'b110, 2'b01);
        push("undefmov_dec", E_DEC); push("undefmov_w", E_WAIT);
        release_s();
        drain();

        // Opcode changes to MOV imm during GET_A of an ADD: path must not change
        start(3'b101, 2'b00);
        push("chg_dec", E_DEC); push("chg_geta", E_GETA); push("chg_getb", E_GETB);
        push("chg_alu", E_ALU0); push("chg_wr", E_WRRD); push("chg_w", E_WAIT);
        release_s();
        @(negedge clk);
        opcode = 3'b110;
        op     = 2'b10;
        drain();

        // Reset during ALU of ADD aborts at once, no write follows
        start(3'b101, 2'b00);
        push("rst_dec", E_DEC); push("rst_geta", E_GETA); push("rst_getb", E_GETB);
        push("rst_alu", E_ALU0); push("rst_w0", E_WAIT); push("rst_w1", E_WAIT);
        release_s();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_async", ctl(), E_WAIT);
        @(negedge clk);
        reset = 1'b0;
        drain();

        // s held high: second DECODE directly after first WAIT
        start(3'b110, 2'b10);
        push("b2b_dec0", E_DEC); push("b2b_wr0", E_WRIMM); push("b2b_w0", E_WAIT);
        push("b2b_dec1", E_DEC); push("b2b_wr1", E_WRIMM); push("b2b_w1", E_WAIT);
        push("b2b_idle", E_WAIT);
        repeat (4) @(negedge clk);
        s = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
